// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
    localparam int unsigned ZERO_IDX  = 0;

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: flush beats issue, issue beats writeback clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          busy1,
    output logic          busy2,
    output logic          any_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                // A hardwired zero register can never have a pending producer.
                if (iss_valid && iss_rd == AW'(i) && !(ZERO_REG != 0 && i == ZERO_IDX)) begin
                    busy_d[i] = 1'b1;
                end else if (we && waddr == AW'(i)) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1    = busy_q[raddr1];
    assign busy2    = busy_q[raddr2];
    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, two combinational read ports and a busy scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic            busy1,
    output logic            busy2,
    output logic            any_busy
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;
    logic            sb_busy1;
    logic            sb_busy2;

    assign wr_en = we && !(ZERO_REG != 0 && waddr == AW'(ZERO_IDX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .waddr     (waddr),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .busy1     (sb_busy1),
        .busy2     (sb_busy2),
        .any_busy  (any_busy)
    );

    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        busy1  = sb_busy1;
        busy2  = sb_busy2;
        if (ZERO_REG != 0 && raddr1 == AW'(ZERO_IDX)) rdata1 = '0;
        if (ZERO_REG != 0 && raddr2 == AW'(ZERO_IDX)) rdata2 = '0;
`ifdef REGFILE_SB_BYPASS_EN
        // wr_en already excludes the hardwired zero register.
        if (wr_en && waddr == raddr1) begin
            rdata1 = wdata;
            busy1  = 1'b0;
        end
        if (wr_en && waddr == raddr2) begin
            rdata2 = wdata;
            busy2  = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench: two register file configurations, directed vectors.
module tb_regfile_sb;
    import regfile_pkg::*;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // Instance A: 32 x 32, ZERO_REG=1
    logic            a_we, a_iss_valid, a_flush, a_busy1, a_busy2, a_any;
    reg_addr_t       a_waddr, a_raddr1, a_raddr2, a_iss_rd;
    logic [31:0]     a_wdata, a_rdata1, a_rdata2;

    // Instance B: 16 x 64, ZERO_REG=0
    logic            b_we, b_iss_valid, b_flush, b_busy1, b_busy2, b_any;
    logic [3:0]      b_waddr, b_raddr1, b_raddr2, b_iss_rd;
    logic [63:0]     b_wdata, b_rdata1, b_rdata2;

    regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .raddr1(a_raddr1), .raddr2(a_raddr2), .rdata1(a_rdata1), .rdata2(a_rdata2),
        .iss_valid(a_iss_valid), .iss_rd(a_iss_rd), .flush(a_flush),
        .busy1(a_busy1), .busy2(a_busy2), .any_busy(a_any)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .raddr1(b_raddr1), .raddr2(b_raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .flush(b_flush),
        .busy1(b_busy1), .busy2(b_busy2), .any_busy(b_any)
    );

    typedef struct {
        int          inst;
        int          port;
        logic [63:0] data;
        logic        busy;
        logic        anyb;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [63:0] d;
            logic        b;
            logic        ab;
            e = exp_q.pop_front();
            if (e.inst == 0) begin
                d  = (e.port == 1) ? {32'b0, a_rdata1} : {32'b0, a_rdata2};
                b  = (e.port == 1) ? a_busy1 : a_busy2;
                ab = a_any;
            end else begin
                d  = (e.port == 1) ? b_rdata1 : b_rdata2;
                b  = (e.port == 1) ? b_busy1 : b_busy2;
                ab = b_any;
            end
            checks++;
            if (d !== e.data || b !== e.busy || ab !== e.anyb) begin
                errors++;
                $display("FAIL %s: got data=%h busy=%b any=%b, want data=%h busy=%b any=%b",
                         e.name, d, b, ab, e.data, e.busy, e.anyb);
            end
        end
    end

    task automatic chk(input int inst, input int port, input logic [63:0] data,
                       input logic busy, input logic anyb, input string name);
        exp_t e;
        e.inst = inst; e.port = port; e.data = data;
        e.busy = busy; e.anyb = anyb; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_we = 0; a_waddr = '0; a_wdata = '0; a_raddr1 = '0; a_raddr2 = '0;
        a_iss_valid = 0; a_iss_rd = '0; a_flush = 0;
    endtask

    task automatic idle_b();
        b_we = 0; b_waddr = '0; b_wdata = '0; b_raddr1 = '0; b_raddr2 = '0;
        b_iss_valid = 0; b_iss_rd = '0; b_flush = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_a();
        idle_b();
        step();
        chk(0, 1, 64'h0, 0, 0, "a_reset");
        chk(1, 2, 64'h0, 0, 0, "b_reset");
        step();
        rst_n = 1'b1;

        // Write then read, same-cycle visibility depends on bypass.
        step();
        a_we = 1; a_waddr = 10; a_wdata = 32'h5; a_raddr1 = 10;
        chk(0, 1, BYP ? 64'h5 : 64'h0, 0, 0, "a_wr_same_cycle");
        step();
        idle_a(); a_raddr1 = 10;
        chk(0, 1, 64'h5, 0, 0, "a_wr_next_cycle");

        // Hardwired zero register.
        step();
        a_we = 1; a_waddr = 0; a_wdata = 32'hFFFF_FFFF;
        a_iss_valid = 1; a_iss_rd = 0; a_raddr1 = 0;
        chk(0, 1, 64'h0, 0, 0, "a_zero_same");
        step();
        idle_a(); a_raddr1 = 0;
        chk(0, 1, 64'h0, 0, 0, "a_zero_next");

        // Issue rd=7, writeback three cycles later.
        step();
        a_iss_valid = 1; a_iss_rd = 7;
        step();
        idle_a(); a_raddr1 = 7;
        chk(0, 1, 64'h0, 1, 1, "a_sb_busy");
        step();
        step();
        a_we = 1; a_waddr = 7; a_wdata = 32'h1234_5678; a_raddr1 = 7;
        chk(0, 1, BYP ? 64'h1234_5678 : 64'h0, BYP ? 1'b0 : 1'b1, 1, "a_sb_wb_same");
        step();
        idle_a(); a_raddr1 = 7;
        chk(0, 1, 64'h1234_5678, 0, 0, "a_sb_cleared");

        // Issue and writeback collide on reg3: issue wins.
        step();
        a_iss_valid = 1; a_iss_rd = 3; a_we = 1; a_waddr = 3; a_wdata = 32'h42;
        step();
        idle_a(); a_raddr2 = 3;
        chk(0, 2, 64'h42, 1, 1, "a_collide");
        step();
        a_we = 1; a_waddr = 3; a_wdata = 32'h43;
        step();
        idle_a(); a_raddr2 = 3;
        chk(0, 2, 64'h43, 0, 0, "a_wb_clear");

        // Flush beats a same-cycle issue.
        step(); a_iss_valid = 1; a_iss_rd = 4;
        step(); a_iss_rd = 5;
        step(); a_iss_rd = 6;
        step();
        idle_a(); a_raddr1 = 4; a_raddr2 = 6;
        a_flush = 1; a_iss_valid = 1; a_iss_rd = 8;
        chk(0, 1, 64'h0, 1, 1, "a_pre_flush_r4");
        chk(0, 2, 64'h0, 1, 1, "a_pre_flush_r6");
        step();
        idle_a(); a_raddr1 = 8; a_raddr2 = 5;
        chk(0, 1, 64'h0, 0, 0, "a_flush_r8");
        chk(0, 2, 64'h0, 0, 0, "a_flush_r5");

        // Asynchronous reset mid-run.
        step();
        a_we = 1; a_waddr = 5; a_wdata = 32'hDEAD_BEEF; a_iss_valid = 1; a_iss_rd = 9;
        step();
        idle_a(); a_raddr1 = 5;
        chk(0, 1, 64'hDEAD_BEEF, 0, 1, "a_pre_reset");
        step();
        rst_n = 1'b0;
        chk(0, 1, 64'h0, 0, 0, "a_async_reset");
        step();
        rst_n = 1'b1;
        a_we = 1; a_waddr = 5; a_wdata = 32'h77;
        step();
        idle_a(); a_raddr1 = 5;
        chk(0, 1, 64'h77, 0, 0, "a_post_reset_wb");

        // Instance B: register 0 is ordinary, 64-bit data.
        step();
        b_we = 1; b_waddr = 0; b_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        b_iss_valid = 1; b_iss_rd = 0;
        step();
        idle_b(); b_raddr1 = 0;
        chk(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, "b_zero_ordinary");
        step();
        b_we = 1; b_waddr = 15; b_wdata = 64'hA5A5_0000_1234_5678;
        step();
        idle_b(); b_raddr2 = 15;
        chk(1, 2, 64'hA5A5_0000_1234_5678, 0, 1, "b_wide_r15");

        step(); b_iss_valid = 1; b_iss_rd = 4;
        step(); b_iss_rd = 5;
        step(); b_iss_rd = 6;
        step();
        idle_b(); b_raddr1 = 4; b_raddr2 = 6;
        b_flush = 1; b_iss_valid = 1; b_iss_rd = 8;
        chk(1, 1, 64'h0, 1, 1, "b_pre_flush_r4");
        chk(1, 2, 64'h0, 1, 1, "b_pre_flush_r6");
        step();
        idle_b(); b_raddr1 = 8; b_raddr2 = 0;
        chk(1, 1, 64'h0, 0, 0, "b_flush_r8");
        chk(1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "b_flush_r0");

        step();
        step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
